// File: rtl/div_issue_pkg.sv
// div_issue_pkg: shared encodings for the EX-stage divide issue logic.
package div_issue_pkg;
    localparam logic [7:0] EXE_DIV_OP        = 8'b00011010;
    localparam logic [7:0] EXE_DIVU_OP       = 8'b00011011;
    localparam logic       DivStart          = 1'b1;
    localparam logic       DivStop           = 1'b0;
    localparam logic       DivResultReady    = 1'b1;
    localparam logic       DivResultNotReady = 1'b0;
    localparam logic       Stop              = 1'b1;
    localparam logic       NoStop            = 1'b0;

    typedef enum logic [1:0] {DivIssueIdle, DivIssueWait, DivIssueDrain} div_issue_state_e;
endpackage

// File: rtl/div_issue.sv
// div_issue: EX-stage initiator for the multi-cycle divider; stalls EX until the result is written to HI/LO.
// Optional macro DIV_ZERO_TRAP_EN traps a zero divisor in IDLE instead of issuing it (adds div_zero_o).
module div_issue
    import div_issue_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic        flush_i,
    input  logic        ex_hold_i,
    input  logic        div_ready_i,
    input  logic [63:0] div_result_i,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_opdata1_o,
    output logic [31:0] div_opdata2_o,
    output logic        stallreq_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
`ifdef DIV_ZERO_TRAP_EN
    ,
    output logic        div_zero_o
`endif
);
    localparam int CW = $clog2(DRAIN_CYCLES + 1);

    div_issue_state_e state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic        start_n, signed_n, is_div, zero_trap, ready;
    logic [31:0] op1_n, op2_n;

    assign is_div      = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
    assign ready       = div_ready_i == DivResultReady;
    assign div_annul_o = flush_i;

`ifdef DIV_ZERO_TRAP_EN
    assign zero_trap  = (state == DivIssueIdle) && is_div && !flush_i && (reg2_i == 32'd0);
    assign div_zero_o = zero_trap;
`else
    assign zero_trap  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= DivIssueIdle;
            cnt           <= '0;
            div_start_o   <= DivStop;
            div_signed_o  <= 1'b0;
            div_opdata1_o <= '0;
            div_opdata2_o <= '0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            div_start_o   <= start_n;
            div_signed_o  <= signed_n;
            div_opdata1_o <= op1_n;
            div_opdata2_o <= op2_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        start_n    = div_start_o;
        signed_n   = div_signed_o;
        op1_n      = div_opdata1_o;
        op2_n      = div_opdata2_o;
        stallreq_o = NoStop;
        whilo_o    = 1'b0;
        hi_o       = '0;
        lo_o       = '0;
        case (state)
            DivIssueIdle: begin
                if (is_div && !flush_i && !zero_trap) begin
                    state_n    = DivIssueWait;
                    start_n    = DivStart;
                    signed_n   = aluop_i == EXE_DIV_OP;
                    op1_n      = reg1_i;
                    op2_n      = reg2_i;
                    stallreq_o = Stop;
                end
            end
            DivIssueWait: begin
                // flush outranks ready; a held-off ready keeps start high so the divider holds its result
                if (flush_i || (ready && !ex_hold_i)) begin
                    state_n = DivIssueDrain;
                    cnt_n   = CW'(DRAIN_CYCLES - 1);
                    start_n = DivStop;
                    whilo_o = !flush_i;
                    hi_o    = flush_i ? 32'd0 : div_result_i[63:32];
                    lo_o    = flush_i ? 32'd0 : div_result_i[31:0];
                end else begin
                    stallreq_o = ready ? NoStop : Stop;
                end
            end
            default: begin
                start_n    = DivStop;
                stallreq_o = (is_div && !flush_i) ? Stop : NoStop;
                cnt_n      = (cnt == '0) ? cnt : cnt - 1'b1;
                state_n    = (cnt == '0 && !ready) ? DivIssueIdle : DivIssueDrain;
            end
        endcase
    end
endmodule
